load_store_unit: RTL and testbench

Parametrised data-memory access unit between the CPU core and the data memory. It replaces the combinational load/store byte extender with a sequential, handshaked unit. Supports XLEN 32 or 64, byte-lane enables, sign/zero extension and stallable memory. Optionally splits misaligned accesses into two beats.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequential handshaked load/store unit; define LSU_MISALIGN_EN for two-beat misaligned accesses
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} stateT;
  stateT state;

  // Request fields captured at accept
  logic             weReg;
  logic [2:0]       funct3Reg;
  logic [OFFW-1:0]  offReg;
`ifdef LSU_MISALIGN_EN
  logic             splitReg;
  logic [XLEN-1:0]  rdata0Reg;
  logic [LANES-1:0] be1Reg;
  logic [XLEN-1:0]  wdata1Reg;
  logic [LANES-1:0] be1;
  logic [XLEN-1:0]  wdata1;
`endif

  // Decoded view of the incoming request
  logic [OFFW-1:0]   reqOff;
  logic [31:0]       sizeBytes;
  logic [31:0]       endByte;
  logic [LANES-1:0]  sizeMask;
  logic              reqSplit;
  logic              reqIllegal;
  logic [ADDR_W-1:0] reqBase;
  logic [LANES-1:0]  be0;
  logic [XLEN-1:0]   wdata0;

  logic [XLEN-1:0]   rawLoad;
  logic [XLEN-1:0]   loadResult;

  assign req_ready = (state == IDLE);

  // Truncate a right-aligned load to its access size, then sign- or zero-extend
  function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    int bits;
    int sh;
    logic [XLEN-1:0] t;
    bits = 8 << f3[1:0];
    if (bits >= XLEN) return raw;
    sh = XLEN - bits;
    t  = raw << sh;
    if (f3[2]) return t >> sh;
    return $unsigned($signed(t) >>> sh);
  endfunction

  // Decode size, lane placement and legality of the request on the port
  always_comb begin
    reqOff    = req_addr[OFFW-1:0];
    sizeBytes = 32'd1 << req_funct3[1:0];
    endByte   = 32'(reqOff) + sizeBytes;
    reqSplit  = endByte > 32'(LANES);
    sizeMask  = LANES'((32'd1 << sizeBytes) - 32'd1);
    reqBase   = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    be0       = sizeMask << reqOff;
    wdata0    = req_wdata << {reqOff, 3'b000};
    reqIllegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    if (XLEN == 32 && (req_funct3 == 3'b011 || req_funct3 == 3'b110)) reqIllegal = 1'b1;
`ifdef LSU_MISALIGN_EN
    be1    = sizeMask >> (32'(LANES) - 32'(reqOff));
    wdata1 = req_wdata >> ((32'(LANES) - 32'(reqOff)) << 3);
`else
    if (reqSplit) reqIllegal = 1'b1;
`endif
  end

  // Stitch the (one or two) read beats into a right-aligned value and extend it
  always_comb begin
    rawLoad = mem_rdata >> {offReg, 3'b000};
`ifdef LSU_MISALIGN_EN
    if (state == BEAT1)
      rawLoad = (rdata0Reg >> {offReg, 3'b000}) |
                (mem_rdata << ((32'(LANES) - 32'(offReg)) << 3));
`endif
    loadResult = extendLoad(rawLoad, funct3Reg);
  end

  // Access sequencer: accept, drive memory beats, emit a one-cycle response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      weReg     <= 1'b0;
      funct3Reg <= 3'b000;
      offReg    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
`ifdef LSU_MISALIGN_EN
      splitReg  <= 1'b0;
      rdata0Reg <= '0;
      be1Reg    <= '0;
      wdata1Reg <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weReg     <= req_we;
            funct3Reg <= req_funct3;
            offReg    <= reqOff;
            if (reqIllegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= BEAT0;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= reqBase;
              mem_be    <= be0;
              mem_wdata <= wdata0;
`ifdef LSU_MISALIGN_EN
              splitReg  <= reqSplit;
              be1Reg    <= be1;
              wdata1Reg <= wdata1;
`endif
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
`ifdef LSU_MISALIGN_EN
            if (splitReg) begin
              state     <= BEAT1;
              rdata0Reg <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(LANES);
              mem_be    <= be1Reg;
              mem_wdata <= wdata1Reg;
            end else
`endif
            begin
              state     <= RESP;
              mem_valid <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_wdata <= '0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= weReg ? '0 : loadResult;
            end
          end
        end
`ifdef LSU_MISALIGN_EN
        BEAT1: begin
          if (mem_ready) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= weReg ? '0 : loadResult;
          end
        end
`endif
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit (XLEN=32)
module tb_load_store_unit;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
`ifdef LSU_MISALIGN_EN
  localparam bit MISALIGN = 1'b1;
`else
  localparam bit MISALIGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata = '0;

  load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: flat byte memory (256 bytes, little-endian); physMem is what the DUT sees
  logic [7:0]  refMem [0:255];
  logic [31:0] physMem [0:63];

  int          readyPct = 100;
  int          beatCount = 0;
  int          waitCount = 0;
  logic [31:0] beatAddr [0:1];
  logic [31:0] beatWdata [0:1];
  logic [3:0]  beatBe [0:1];

  // Memory responder: random ready, single-cycle read data, byte-enabled writes
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_valid) begin
      if (int'($urandom_range(1, 100)) <= readyPct) begin
        mem_ready = 1'b1;
        if (beatCount < 2) begin
          beatAddr[beatCount]  = mem_addr;
          beatWdata[beatCount] = mem_wdata;
          beatBe[beatCount]    = mem_be;
        end
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) physMem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata = physMem[mem_addr[7:2]];
        end
        beatCount++;
      end else begin
        waitCount++;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic setWord(input logic [7:0] addr, input logic [31:0] w);
    int base;
    base = int'(addr) & 252;
    physMem[addr[7:2]] = w;
    for (int i = 0; i < 4; i++) refMem[base + i] = w[8*i +: 8];
  endtask

  function automatic int sizeOf(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit crossesWord(input logic [31:0] addr, input logic [2:0] f3);
    return (int'(addr[1:0]) + sizeOf(f3)) > 4;
  endfunction

  function automatic bit isIllegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    return (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110) || (we && f3[2]) ||
           (!MISALIGN && crossesWord(addr, f3));
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    int size;
    size = sizeOf(f3);
    v = 0;
    for (int i = 0; i < size; i++) v |= 32'(refMem[(int'(addr[7:0]) + i) & 255]) << (8 * i);
    if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wdata);
    for (int i = 0; i < sizeOf(f3); i++) refMem[(int'(addr[7:0]) + i) & 255] = wdata[8*i +: 8];
  endtask

  task automatic startReq(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    beatCount = 0;
    waitCount = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(output logic [31:0] rdata, output logic err, output int lat, output bit timedOut);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    timedOut = !rsp_valid;
    rdata = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic runReq(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat, output bit timedOut);
    startReq(we, f3, addr, wdata);
    waitRsp(rdata, err, lat, timedOut);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if ({rsp_valid, rsp_err, mem_valid, mem_we} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {rsp_valid, rsp_err, mem_valid, mem_we}); end
    vectors++; if ({rsp_rdata, mem_addr, mem_wdata, mem_be} !== '0) begin miscompares++; $display("FAIL reset_buses got %h want 0", {rsp_rdata, mem_addr, mem_wdata, mem_be}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset got ready=%b mvalid=%b want 1 0", req_ready, mem_valid); end
  endtask

  task automatic test_store_word();
    logic [31:0] rd; logic err; int lat; bit to;
    readyPct = 100;
    runReq(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, err, lat, to);
    refStore(32'h100, 3'b010, 32'hDEADBEEF);
    vectors++; if (to || lat != 2) begin miscompares++; $display("FAIL sw_latency got %0d want 2", lat); end
    vectors++; if (err !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL sw_rsp got err=%b rd=%h want 0 0", err, rd); end
    vectors++; if (beatAddr[0] !== 32'h100 || beatBe[0] !== 4'hF || beatWdata[0] !== 32'hDEADBEEF)
      begin miscompares++; $display("FAIL sw_beat got %h %b %h want 100 1111 deadbeef", beatAddr[0], beatBe[0], beatWdata[0]); end
  endtask

  task automatic test_load_byte();
    logic [31:0] rd; logic err; int lat; bit to;
    setWord(8'h00, 32'h80FF0000);
    runReq(1'b0, 3'b000, 32'h103, 32'h0, rd, err, lat, to);
    vectors++; if (to || err !== 1'b0 || rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_sign got %h want ffffff80", rd); end
    vectors++; if (beatAddr[0] !== 32'h100) begin miscompares++; $display("FAIL lb_addr got %h want 00000100", beatAddr[0]); end
    runReq(1'b0, 3'b100, 32'h103, 32'h0, rd, err, lat, to);
    vectors++; if (to || err !== 1'b0 || rd !== 32'h00000080) begin miscompares++; $display("FAIL lbu_zero got %h want 00000080", rd); end
  endtask

  task automatic test_store_half();
    logic [31:0] rd; logic err; int lat; bit to;
    runReq(1'b1, 3'b001, 32'h102, 32'h00001234, rd, err, lat, to);
    refStore(32'h102, 3'b001, 32'h00001234);
    vectors++; if (to || beatBe[0] !== 4'b1100 || beatWdata[0] !== 32'h12340000)
      begin miscompares++; $display("FAIL sh_lanes got %b %h want 1100 12340000", beatBe[0], beatWdata[0]); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err; int lat; bit to;
    setWord(8'h00, 32'hAABBCCDD);
    setWord(8'h04, 32'h11223344);
    runReq(1'b0, 3'b010, 32'h102, 32'h0, rd, err, lat, to);
`ifdef LSU_MISALIGN_EN
    vectors++; if (to || err !== 1'b0 || rd !== 32'h3344AABB) begin miscompares++; $display("FAIL lw_split_data got %h want 3344aabb", rd); end
    vectors++; if (lat != 3 || beatCount != 2) begin miscompares++; $display("FAIL lw_split_timing got lat=%0d beats=%0d want 3 2", lat, beatCount); end
    vectors++; if (beatAddr[0] !== 32'h100 || beatAddr[1] !== 32'h104) begin miscompares++; $display("FAIL lw_split_addr got %h %h want 100 104", beatAddr[0], beatAddr[1]); end
`else
    vectors++; if (to || err !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL lw_split_err got err=%b rd=%h want 1 0", err, rd); end
    vectors++; if (lat != 1 || beatCount != 0) begin miscompares++; $display("FAIL lw_split_timing got lat=%0d beats=%0d want 1 0", lat, beatCount); end
`endif
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic err; int lat; bit to;
    logic [3:0] cases [0:2];
    cases[0] = 4'b0111; cases[1] = 4'b0011; cases[2] = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      runReq(cases[i][3], cases[i][2:0], 32'h108, 32'h55AA55AA, rd, err, lat, to);
      vectors++; if (to || err !== 1'b1 || rd !== 32'h0 || lat != 1 || beatCount != 0)
        begin miscompares++; $display("FAIL illegal_%0d got err=%b rd=%h lat=%0d beats=%0d want 1 0 1 0", i, err, rd, lat, beatCount); end
    end
  endtask

  task automatic test_stall_and_abort();
    logic [31:0] rd; logic err; int lat; bit to;
    setWord(8'h40, 32'h5A5A1234);
    readyPct = 0;
    startReq(1'b0, 3'b010, 32'h140, 32'h0);
    for (int c = 0; c < 5; c++) begin
      vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h140 || mem_be !== 4'hF || mem_we !== 1'b0 || rsp_valid !== 1'b0)
        begin miscompares++; $display("FAIL stall_hold_%0d got v=%b a=%h be=%b we=%b want 1 140 1111 0", c, mem_valid, mem_addr, mem_be, mem_we); end
      @(negedge clk);
    end
    readyPct = 100;
    waitRsp(rd, err, lat, to);
    vectors++; if (to || err !== 1'b0 || rd !== 32'h5A5A1234) begin miscompares++; $display("FAIL stall_data got %h want 5a5a1234", rd); end
    readyPct = 0;
    startReq(1'b0, 3'b010, 32'h144, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL abort_async got mvalid=%b ready=%b want 0 1", mem_valid, req_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    readyPct = 100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin miscompares++; $display("FAIL abort_quiet_%0d got rvalid=%b mvalid=%b want 0 0", c, rsp_valid, mem_valid); end
    end
  endtask

  task automatic test_random_traffic();
    logic [31:0] rd, addr, wdata, expData; logic err, we, expErr; logic [2:0] f3; int lat, expBeats; bit to;
    readyPct = 70;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        f3 = 3'($urandom_range(0, 2));
        if (!we && f3 != 3'b010 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      end
      addr  = 32'h100 | 32'($urandom_range(0, 255));
      wdata = $urandom;
      expErr   = isIllegal(we, f3, addr);
      expBeats = expErr ? 0 : (crossesWord(addr, f3) ? 2 : 1);
      expData  = (!we && !expErr) ? refLoad(addr, f3) : 32'h0;
      runReq(we, f3, addr, wdata, rd, err, lat, to);
      if (we && !expErr) refStore(addr, f3, wdata);
      vectors++; if (to || err !== expErr || rd !== expData)
        begin miscompares++; $display("FAIL rand_%0d we=%b f3=%b a=%h got err=%b rd=%h want %b %h", n, we, f3, addr, err, rd, expErr, expData); end
      vectors++; if (beatCount != expBeats || lat != 1 + expBeats + waitCount)
        begin miscompares++; $display("FAIL rand_timing_%0d got beats=%0d lat=%0d want %0d %0d", n, beatCount, lat, expBeats, 1 + expBeats + waitCount); end
    end
    for (int w = 0; w < 64; w++) begin
      vectors++; if (physMem[w] !== {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]})
        begin miscompares++; $display("FAIL mem_word_%0d got %h want %h", w, physMem[w], {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]}); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
    for (int w = 0; w < 64; w++) physMem[w] = {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_illegal();
    test_stall_and_abort();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
